// File: rtl/parking_ctrl_n_pkg.sv
// Shared types and helpers for the parking-garage controller.
package parking_ctrl_n_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_t;

  localparam int unsigned FILL_LOW  = 0;
  localparam int unsigned FILL_HIGH = 1;

  // Index width for n spots, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parking_ctrl_n_prio_enc.sv
// Free-spot priority encoder: picks the lowest or highest free index.
module park_prio_enc
  import parking_ctrl_n_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned FILL_POLICY = FILL_LOW,
  localparam int unsigned IW         = idx_width(N)
) (
  input  logic [N-1:0]  free_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Last hit wins: descending scan keeps the lowest, ascending keeps the highest.
  always_comb begin
    idx_o   = (FILL_POLICY == FILL_HIGH) ? IW'(N - 1) : '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (FILL_POLICY == FILL_HIGH) begin
        if (free_i[i]) begin
          idx_o   = IW'(i);
          valid_o = 1'b1;
        end
      end else if (free_i[N-1-i]) begin
        idx_o   = IW'(N - 1 - i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_ctrl_n.sv
// Parking-garage controller: occupancy bitmap, nearest-spot assignment,
// timed gate light, full flag and one-cycle reject pulse.
module parking_ctrl_n
  import parking_ctrl_n_pkg::*;
#(
  parameter int unsigned NUM_SPOTS   = 8,
  parameter int unsigned DOOR_CYCLES = 16,
  parameter int unsigned FILL_POLICY = FILL_LOW,
  localparam int unsigned IDXW       = idx_width(NUM_SPOTS),
  localparam int unsigned CNTW       = $clog2(NUM_SPOTS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 entry,
  input  logic                 exit,
  input  logic [IDXW-1:0]      Ex,
  output logic [NUM_SPOTS-1:0] parking_lights,
  output logic [CNTW-1:0]      capacity,
  output logic [IDXW-1:0]      nearest_park,
  output logic                 nearest_valid,
  output logic                 light_door_open,
  output logic                 light_full_garage,
  output logic                 reject
);

  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [IDXW-1:0] NEAR_RST =
    (FILL_POLICY == FILL_HIGH) ? IDXW'(NUM_SPOTS - 1) : '0;

  state_t               state_q;
  logic [DW-1:0]        dwell_q;
  logic [NUM_SPOTS-1:0] lights_q, lights_d;
  logic [CNTW-1:0]      cap_q, cap_d, occ;
  logic [IDXW-1:0]      near_q, near_d;
  logic                 valid_q, valid_d;
  logic                 reject_q, reject_d;
  logic                 entry_ok, exit_ok, accept;

  // Judge both events against pre-event state; the entry uses the registered
  // nearest spot, which is free, so it can never collide with the exiting spot.
  always_comb begin
    entry_ok = (state_q == ST_IDLE) && entry && (cap_q != '0);
    exit_ok  = (state_q == ST_IDLE) && exit && (32'(Ex) < NUM_SPOTS) && lights_q[Ex];
    accept   = entry_ok || exit_ok;
    reject_d = (entry && !entry_ok) || (exit && !exit_ok);
    lights_d = lights_q;
    if (entry_ok) lights_d[near_q] = 1'b1;
    if (exit_ok)  lights_d[Ex]     = 1'b0;
    occ = '0;
    for (int unsigned i = 0; i < NUM_SPOTS; i++) begin
      occ = occ + CNTW'(lights_d[i]);
    end
    cap_d = CNTW'(NUM_SPOTS) - occ;
  end

  park_prio_enc #(
    .N          (NUM_SPOTS),
    .FILL_POLICY(FILL_POLICY)
  ) u_enc (
    .free_i (~lights_d),
    .idx_o  (near_d),
    .valid_o(valid_d)
  );

  // Gate FSM: dwell counts 1..DOOR_CYCLES while open, refusing new events.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_OPEN;
            dwell_q <= DW'(1);
          end
        end
        ST_OPEN: begin
          if (dwell_q == DW'(DOOR_CYCLES)) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          dwell_q <= '0;
        end
      endcase
    end
  end

  // Occupancy, derived counts and reject pulse registered together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lights_q <= '0;
      cap_q    <= CNTW'(NUM_SPOTS);
      near_q   <= NEAR_RST;
      valid_q  <= 1'b1;
      reject_q <= 1'b0;
    end else begin
      lights_q <= lights_d;
      cap_q    <= cap_d;
      near_q   <= near_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
    end
  end

  assign parking_lights    = lights_q;
  assign capacity          = cap_q;
  assign nearest_park      = near_q;
  assign nearest_valid     = valid_q;
  assign light_door_open   = (state_q == ST_OPEN);
  assign light_full_garage = (cap_q == '0);
  assign reject            = reject_q;

endmodule
